instr_fetch_unit: RTL and testbench

- Upstream fetch stage of the multicycle CPU.
- Owns the PC and issues instruction-memory reads.
- Latches the returned word into the instruction register and presents it as `ins` to the control decoder with a valid/accept handshake.
- Applies next-PC selection (sequential or jump/branch redirect from the datapath) when the decoder retires the instruction.

---
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Upstream fetch stage of the multicycle CPU. Owns the PC, issues one
//   instruction-memory read per instruction, and holds the returned word in
//   the instruction register until the decoder retires it. On retire, the next
//   PC is either pc+4 or the redirect target supplied by the datapath.
//
// Ports:
//   clock, reset_n          - single clock, asynchronous active-low reset
//   imem_req/addr           - read request; address is always the pc register
//   imem_rdata/ready        - read data with a single-cycle strobe
//   ins/ins_valid           - instruction register and its valid flag
//   ins_accept              - decoder retires ins
//   redirect_en/target      - next-PC redirect sampled on retire
//   pc, pc_plus4            - address of ins, and pc+4 (jal link value)
//   fetch_err               - sticky instruction-memory timeout
//   align_err               - sticky misaligned redirect (FETCH_ALIGN_CHECK_EN only)
//
// Build option: define FETCH_ALIGN_CHECK_EN to add the align_err port and
// force redirect targets to word alignment.

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] ins,
    output logic        ins_valid,
    input  logic        ins_accept,
    input  logic        redirect_en,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        align_err
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        align_err_q, align_err_d;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            ins_q       <= 32'h0;
            wait_cnt_q  <= 8'h0;
            fetch_err_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            align_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
`ifdef FETCH_ALIGN_CHECK_EN
            align_err_q <= align_err_d;
`endif
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_pc = {redirect_target[31:2], 2'b00};
`else
    assign redirect_pc = redirect_target;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        wait_cnt_d  = wait_cnt_q;
        fetch_err_d = fetch_err_q;
`ifdef FETCH_ALIGN_CHECK_EN
        align_err_d = align_err_q;
`endif
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    ins_d      = imem_rdata;
                    wait_cnt_d = 8'h0;
                    state_d    = HOLD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    fetch_err_d = 1'b1;
                    wait_cnt_d  = 8'h0;
                    state_d     = HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            HOLD: begin
                // Decoder may keep ins here for several cycles (lw/sw).
                if (ins_accept) begin
                    state_d = FETCH;
                    if (redirect_en) begin
                        pc_d = redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
                        if (redirect_target[1:0] != 2'b00) align_err_d = 1'b1;
`endif
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // Gate with reset_n so the request drops the instant reset asserts,
    // rather than being held high by the FETCH reset state.
    assign imem_req  = (state_q == FETCH) && reset_n;
    assign imem_addr = pc_q;
    assign ins       = ins_q;
    assign ins_valid = (state_q == HOLD);
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign fetch_err = fetch_err_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign align_err = align_err_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n, rst_to_n;
    logic        imem_req, imem_ready, ins_valid, ins_accept, redirect_en, fetch_err;
    logic [31:0] imem_addr, imem_rdata, ins, redirect_target, pc, pc_plus4;
    // timeout instance: memory never answers
    logic        to_req, to_valid, to_err;
    logic [31:0] to_addr, to_ins, to_pc, to_pc4;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        align_err, to_align;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    instr_fetch_unit dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .ins(ins), .ins_valid(ins_valid),
        .ins_accept(ins_accept), .redirect_en(redirect_en),
        .redirect_target(redirect_target), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_err(fetch_err)
`ifdef FETCH_ALIGN_CHECK_EN
        , .align_err(align_err)
`endif
    );

    instr_fetch_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clock(clock), .reset_n(rst_to_n),
        .imem_req(to_req), .imem_addr(to_addr), .imem_rdata(zero32),
        .imem_ready(zero1), .ins(to_ins), .ins_valid(to_valid),
        .ins_accept(zero1), .redirect_en(zero1),
        .redirect_target(zero32), .pc(to_pc), .pc_plus4(to_pc4),
        .fetch_err(to_err)
`ifdef FETCH_ALIGN_CHECK_EN
        , .align_err(to_align)
`endif
    );

    typedef struct {
        logic        rdy;
        logic [31:0] rdata;
        logic        acc;
        logic        ren;
        logic [31:0] tgt;
        logic        req;
        logic        vld;
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pc4;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic rdy, input logic [31:0] rd, input logic acc,
                         input logic ren, input logic [31:0] tgt);
        imem_ready = rdy; imem_rdata = rd; ins_accept = acc;
        redirect_en = ren; redirect_target = tgt;
    endtask

    initial begin
        // inputs/expected outputs for one cycle, checked before that cycle's edge
        //          rdy rdata          acc ren tgt            req vld ins            pc             pc4
        tbl[0]  = '{1, 32'h8C00_0004, 0, 0, 32'h0,         1, 0, 32'h0,         32'h0,         32'h4};
        tbl[1]  = '{0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h8C00_0004, 32'h0,         32'h4};
        tbl[2]  = '{0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h8C00_0004, 32'h0,         32'h4};
        tbl[3]  = '{0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h8C00_0004, 32'h4,         32'h8};
        tbl[4]  = tbl[3];
        tbl[5]  = tbl[3];
        tbl[6]  = tbl[3];
        tbl[7]  = '{1, 32'h0022_1820, 0, 0, 32'h0,         1, 0, 32'h8C00_0004, 32'h4,         32'h8};
        tbl[8]  = '{1, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 1, 32'h0022_1820, 32'h4,         32'h8};
        tbl[9]  = tbl[8];
        tbl[10] = tbl[8];
        tbl[11] = '{0, 32'h0,         1, 1, 32'h100,       0, 1, 32'h0022_1820, 32'h4,         32'h8};
        tbl[12] = '{1, 32'hAC00_0000, 1, 0, 32'h0,         1, 0, 32'h0022_1820, 32'h100,       32'h104};
        tbl[13] = '{0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 1, 32'hAC00_0000, 32'h100,       32'h104};
        tbl[14] = '{1, 32'h1234_5678, 0, 0, 32'h0,         1, 0, 32'hAC00_0000, 32'hFFFF_FFFC, 32'h0};
        tbl[15] = '{0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0};
        tbl[16] = '{0, 32'h0,         0, 1, 32'h200,       1, 0, 32'h1234_5678, 32'h0,         32'h4};

        reset_n = 1'b0; rst_to_n = 1'b0;
        drive(0, 32'h0, 0, 0, 32'h0);
        repeat (2) @(negedge clock);
        #1;
        chk("rst imem_req", 32'(imem_req), 32'h0);
        chk("rst ins_valid", 32'(ins_valid), 32'h0);
        chk("rst ins", ins, 32'h0);
        chk("rst pc", pc, 32'h0);
        chk("rst fetch_err", 32'(fetch_err), 32'h0);

        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i != 0) @(negedge clock);
            drive(tbl[i].rdy, tbl[i].rdata, tbl[i].acc, tbl[i].ren, tbl[i].tgt);
            #1;
            chk($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(tbl[i].req));
            chk($sformatf("v%0d ins_valid", i), 32'(ins_valid), 32'(tbl[i].vld));
            chk($sformatf("v%0d ins", i), ins, tbl[i].ins);
            chk($sformatf("v%0d pc", i), pc, tbl[i].pc);
            chk($sformatf("v%0d imem_addr", i), imem_addr, tbl[i].pc);
            chk($sformatf("v%0d pc_plus4", i), pc_plus4, tbl[i].pc4);
            chk($sformatf("v%0d fetch_err", i), 32'(fetch_err), 32'h0);
        end

`ifdef FETCH_ALIGN_CHECK_EN
        // misaligned redirect: forced to word address, align_err sticks
        @(negedge clock); drive(1, 32'h0, 0, 0, 32'h0); #1;
        chk("al fetch addr", imem_addr, 32'h0);
        @(negedge clock); drive(0, 32'h0, 1, 1, 32'h102); #1;
        chk("al hold valid", 32'(ins_valid), 32'h1);
        chk("al before", 32'(align_err), 32'h0);
        @(negedge clock); drive(0, 32'h0, 0, 0, 32'h0); #1;
        chk("al addr", imem_addr, 32'h100);
        chk("al align_err", 32'(align_err), 32'h1);
        chk("al req", 32'(imem_req), 32'h1);
`endif

        // reset mid-FETCH: request drops without waiting for a clock
        @(negedge clock); drive(0, 32'h0, 0, 0, 32'h0); #1;
        chk("mid req before", 32'(imem_req), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid req async", 32'(imem_req), 32'h0);
        chk("mid pc", pc, 32'h0);
        chk("mid ins", ins, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mid align_err", 32'(align_err), 32'h0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        drive(1, 32'h1111_1111, 0, 0, 32'h0); #1;
        chk("post req", 32'(imem_req), 32'h1);
        chk("post addr", imem_addr, 32'h0);
        @(negedge clock); drive(0, 32'h0, 0, 0, 32'h0); #1;
        chk("post valid", 32'(ins_valid), 32'h1);
        chk("post ins", ins, 32'h1111_1111);

        // timeout instance, TIMEOUT_CYCLES=4
        @(negedge clock);
        rst_to_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("to c%0d req", k), 32'(to_req), 32'h1);
            chk($sformatf("to c%0d err", k), 32'(to_err), 32'h0);
            @(negedge clock);
        end
        #1;
        chk("to err set", 32'(to_err), 32'h1);
        chk("to req off", 32'(to_req), 32'h0);
        chk("to valid off", 32'(to_valid), 32'h0);
        repeat (3) @(negedge clock);
        #1;
        chk("to err sticky", 32'(to_err), 32'h1);
        chk("to halt req", 32'(to_req), 32'h0);
        rst_to_n = 1'b0; #1;
        chk("to rst err", 32'(to_err), 32'h0);
        @(negedge clock);
        rst_to_n = 1'b1; #1;
        chk("to restart req", 32'(to_req), 32'h1);
        chk("to restart addr", to_addr, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
